line_buffer_multi: RTL and testbench
====================================

# line_buffer_multi

Parametrised N-line video line buffer holding the last NUM_LINES-1 completed lines in rotating block-RAM banks. Samples are written during the effective region, with optional decimation, and the write bank advances automatically at each line end. Two independent read ports address any completed line by age, with a fixed-latency valid strobe. The block sits between the receive front end and the send/processing stage, and replaces external ping-pong flag and write-pointer generation.

## Interface
Parameters:
- VIDEO_DATA_WIDTH, 18, sample width.
- RAM_DEPTH, 100, samples per line bank.
- NUM_LINES, 4, number of banks; minimum 2; NUM_LINES-1 lines are readable.
- TIMES, 1, write decimation: one sample kept per TIMES ce cycles.
- ADDR_WIDTH (localparam), clogb2(RAM_DEPTH-1).
- LINE_WIDTH (localparam), clogb2(NUM_LINES-1), minimum 1.

Ports:
- clk, in, 1, single clock for all logic and RAMs.
- sclr, in, 1, synchronous active-high reset.
- ce, in, 1, sample-cycle enable for the write side.
- flush, in, 1, one-cycle pulse that invalidates all stored lines (frame start).
- video_data_in, in, VIDEO_DATA_WIDTH, input sample.
- effect_reigon, in, 1, effective-region flag; high for the duration of a line.
- rda_req / rdb_req, in, 1, read request pulse per port.
- rda_line / rdb_line, in, LINE_WIDTH, line age; 0 = most recent completed line.
- rda_addr / rdb_addr, in, ADDR_WIDTH, sample index.
- rda_data / rdb_data, out, VIDEO_DATA_WIDTH, read data.
- rda_valid / rdb_valid, out, 1, read data strobe.
- rda_err / rdb_err, out, 1, qualifies valid; high when the requested line or address is not available.
- lines_avail, out, LINE_WIDTH+1, completed lines readable, 0..NUM_LINES-1.
- line_len, out, ADDR_WIDTH+1, sample count of the most recent completed line.
- line_done, out, 1, one-cycle pulse when a line completes.
- ovf, out, 1, sticky flag; line exceeded RAM_DEPTH.

## Operation
- Reset: every output is 0. wr_bank=0, wr_cnt=0, phase=0, and all in-flight reads are dropped. RAM contents are not cleared.
- Region edges use effect_reigon_d1, which is registered on ce cycles only:
  - Rise: ce & effect_reigon & !effect_reigon_d1.
  - Fall (line end): ce & !effect_reigon & effect_reigon_d1.
- Decimation:
  - phase clears to 0 at region rise.
  - phase increments mod TIMES on each ce cycle inside the region.
  - A sample is accepted when ce & effect_reigon & phase==0.
- Write stage: an accepted sample registers {data, wr_bank, wr_cnt} and is written on port A of bank wr_bank the next cycle. wr_cnt then increments.
- Overflow: if wr_cnt==RAM_DEPTH, the sample is dropped and ovf is set. ovf is cleared only by sclr.
- Line end with wr_cnt>0:
  - line_len<=wr_cnt.
  - wr_bank<=(wr_bank+1) mod NUM_LINES.
  - wr_cnt<=0.
  - lines_avail increments, saturating at NUM_LINES-1.
  - line_done pulses.
- Line end with wr_cnt==0: ignored (empty line); no pulse.
- flush: lines_avail<=0. wr_bank and line_len are unchanged. If flush and line end occur in the same cycle, flush wins and lines_avail=0.
- Read decode: bank=(wr_bank-1-rd_line) mod NUM_LINES, computed from the pre-update wr_bank and lines_avail in the request cycle.
  - Port A reads share RAM port A. The write bank is never a legal read bank, so there is no conflict.
  - Port B reads use RAM port B.
- Read error when rd_line>=lines_avail or rd_addr>=the stored length of that line:
  - No RAM enable.
  - data=0, valid=1, err=1.
- Per-bank stored lengths are kept in a NUM_LINES-entry register array written at line end.

## Timing
- Write: sample accepted at cycle t; RAM write at t+1. Readback of that address is legal only after line_done.
- Read latency is 3 cycles, req to valid:
  - t: address/enable to RAM.
  - t+1: RAM array register.
  - t+2: RAM output register (HIGH_PERFORMANCE).
  - t+3: bank-mux output register; valid/err asserted.
- Back-to-back requests every cycle are supported on both ports. Valid is a one-cycle pulse per request.
- A line end and a read request in the same cycle: the read targets the pre-advance mapping. line_done, lines_avail and line_len update at t+1.
- sclr mid-read: valid is forced to 0 in the following cycle; pipeline contents are discarded.
- wr_bank wrap: NUM_LINES-1 -> 0.

## Test plan
- NUM_LINES=4, TIMES=1: write 3 lines of 10 samples (value=line*100+idx), then read A line=2 addr=5 -> rda_data=5, valid 3 cycles after req; line=0 addr=9 -> 209; lines_avail=3.
- 5 lines written -> lines_avail saturates at 3. B line=0 addr=0 -> 400. wr_bank wraps to 1.
- TIMES=3, region of 9 ce cycles with data 0..8 -> line_len=3, stored samples 0, 3, 6.
- A region of 120 samples with RAM_DEPTH=100 -> ovf=1, line_len=100, addr 99 holds 99.
- A and B read in the same cycle as a line end, after 1 line exists -> both return the old line 0. The next request with line=0 returns the new line.
- Errors: a request with line>=lines_avail, or after flush, or with addr>=line_len -> valid=1, err=1, data=0. sclr mid-burst -> no valid after the reset cycle.

Source files
------------

// File: rtl/line_buffer_multi_if.sv
// Signal bundle for line_buffer_multi: write-side video input, two read
// ports and line status. slave = buffer side, master = driver side.
interface line_buffer_multi_if #(
    parameter int VIDEO_DATA_WIDTH = 18,
    parameter int RAM_DEPTH        = 100,
    parameter int NUM_LINES        = 4
);
    localparam int ADDR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int LINE_WIDTH = (NUM_LINES > 2) ? $clog2(NUM_LINES) : 1;

    logic                        ce;
    logic                        flush;
    logic [VIDEO_DATA_WIDTH-1:0] video_data_in;
    logic                        effect_reigon;

    logic                        rda_req;
    logic [LINE_WIDTH-1:0]       rda_line;
    logic [ADDR_WIDTH-1:0]       rda_addr;
    logic [VIDEO_DATA_WIDTH-1:0] rda_data;
    logic                        rda_valid;
    logic                        rda_err;

    logic                        rdb_req;
    logic [LINE_WIDTH-1:0]       rdb_line;
    logic [ADDR_WIDTH-1:0]       rdb_addr;
    logic [VIDEO_DATA_WIDTH-1:0] rdb_data;
    logic                        rdb_valid;
    logic                        rdb_err;

    logic [LINE_WIDTH:0]         lines_avail;
    logic [ADDR_WIDTH:0]         line_len;
    logic                        line_done;
    logic                        ovf;

    modport slave (
        input  ce, flush, video_data_in, effect_reigon,
        input  rda_req, rda_line, rda_addr,
        input  rdb_req, rdb_line, rdb_addr,
        output rda_data, rda_valid, rda_err,
        output rdb_data, rdb_valid, rdb_err,
        output lines_avail, line_len, line_done, ovf
    );

    modport master (
        output ce, flush, video_data_in, effect_reigon,
        output rda_req, rda_line, rda_addr,
        output rdb_req, rdb_line, rdb_addr,
        input  rda_data, rda_valid, rda_err,
        input  rdb_data, rdb_valid, rdb_err,
        input  lines_avail, line_len, line_done, ovf
    );
endinterface

// File: rtl/line_buffer_multi.sv
// N-bank rotating video line buffer: decimated writes during the effective
// region, automatic bank advance at line end, two 3-cycle read ports by age.
module line_buffer_multi #(
    parameter int VIDEO_DATA_WIDTH = 18,
    parameter int RAM_DEPTH        = 100,
    parameter int NUM_LINES        = 4,
    parameter int TIMES            = 1
) (
    input logic                clk,
    input logic                sclr,
    line_buffer_multi_if.slave bus
);
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int LW = (NUM_LINES > 2) ? $clog2(NUM_LINES) : 1;
    localparam int PW = (TIMES > 1) ? $clog2(TIMES) : 1;

    typedef logic [VIDEO_DATA_WIDTH-1:0] data_t;

    logic          er_d1;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_cur;
    logic [LW-1:0] wr_bank;
    logic [AW:0]   wr_cnt;
    logic [AW:0]   len_q [NUM_LINES];
    logic          rise, fall, accept, line_end;

    logic          wr_en;
    logic [LW-1:0] wr_bank_q;
    logic [AW-1:0] wr_addr;
    data_t         wr_data;

    logic [LW-1:0] a_bank, b_bank;
    logic          a_err, b_err, a_en, b_en;

    function automatic logic [LW-1:0] bank_of(
        input logic [LW-1:0] wb,
        input logic [LW-1:0] line
    );
        int t;
        t = (int'(wb) + 2 * NUM_LINES - 1 - int'(line)) % NUM_LINES;
        return LW'(t);
    endfunction

    always_comb begin
        rise      = bus.ce & bus.effect_reigon & ~er_d1;
        fall      = bus.ce & ~bus.effect_reigon & er_d1;
        phase_cur = rise ? '0 : phase;
        accept    = bus.ce & bus.effect_reigon & (phase_cur == '0);
        line_end  = fall & (wr_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            er_d1           <= 1'b0;
            phase           <= '0;
            wr_bank         <= '0;
            wr_cnt          <= '0;
            wr_en           <= 1'b0;
            bus.ovf         <= 1'b0;
            bus.line_len    <= '0;
            bus.line_done   <= 1'b0;
            bus.lines_avail <= '0;
            for (int i = 0; i < NUM_LINES; i++) len_q[i] <= '0;
        end else begin
            wr_en         <= 1'b0;
            bus.line_done <= 1'b0;
            if (bus.ce) er_d1 <= bus.effect_reigon;
            if (bus.ce && bus.effect_reigon)
                phase <= (phase_cur == PW'(TIMES - 1)) ? '0 : phase_cur + 1'b1;
            if (accept) begin
                if (wr_cnt == (AW + 1)'(RAM_DEPTH)) begin
                    bus.ovf <= 1'b1;
                end else begin
                    wr_en     <= 1'b1;
                    wr_bank_q <= wr_bank;
                    wr_addr   <= wr_cnt[AW-1:0];
                    wr_data   <= bus.video_data_in;
                    wr_cnt    <= wr_cnt + 1'b1;
                end
            end
            if (line_end) begin
                bus.line_len   <= wr_cnt;
                len_q[wr_bank] <= wr_cnt;
                wr_bank <= (wr_bank == LW'(NUM_LINES - 1)) ? '0 : wr_bank + 1'b1;
                wr_cnt         <= '0;
                bus.line_done  <= 1'b1;
            end
            // flush takes priority over a coincident line end
            if (bus.flush)
                bus.lines_avail <= '0;
            else if (line_end && bus.lines_avail != (LW + 1)'(NUM_LINES - 1))
                bus.lines_avail <= bus.lines_avail + 1'b1;
        end
    end

    // Decode uses the pre-update bank pointer, lengths and line count
    always_comb begin
        a_bank = bank_of(wr_bank, bus.rda_line);
        b_bank = bank_of(wr_bank, bus.rdb_line);
        a_err  = ({1'b0, bus.rda_line} >= bus.lines_avail)
               | ({1'b0, bus.rda_addr} >= len_q[a_bank]);
        b_err  = ({1'b0, bus.rdb_line} >= bus.lines_avail)
               | ({1'b0, bus.rdb_addr} >= len_q[b_bank]);
        a_en   = bus.rda_req & ~a_err;
        b_en   = bus.rdb_req & ~b_err;
    end

    data_t doa_q [NUM_LINES];
    data_t dob_q [NUM_LINES];

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_bank
        data_t         mem [RAM_DEPTH];
        data_t         doa_r, dob_r;
        logic          we, ra, rb;
        logic [AW-1:0] adr_a;

        assign we    = wr_en & (wr_bank_q == LW'(g));
        assign ra    = a_en & (a_bank == LW'(g));
        assign rb    = b_en & (b_bank == LW'(g));
        assign adr_a = we ? wr_addr : bus.rda_addr;

        always_ff @(posedge clk) begin
            if (we)
                mem[adr_a] <= wr_data;
            else if (ra)
                doa_r <= mem[adr_a];
            if (rb) dob_r <= mem[bus.rdb_addr];
            doa_q[g] <= doa_r;
            dob_q[g] <= dob_r;
        end
    end

    logic [1:0]    a_v, a_e, b_v, b_e;
    logic [LW-1:0] a_b1, a_b2, b_b1, b_b2;

    always_ff @(posedge clk) begin
        if (sclr) begin
            a_v           <= '0;
            b_v           <= '0;
            bus.rda_valid <= 1'b0;
            bus.rda_err   <= 1'b0;
            bus.rda_data  <= '0;
            bus.rdb_valid <= 1'b0;
            bus.rdb_err   <= 1'b0;
            bus.rdb_data  <= '0;
        end else begin
            a_v  <= {a_v[0], bus.rda_req};
            a_e  <= {a_e[0], a_err};
            a_b1 <= a_bank;
            a_b2 <= a_b1;
            b_v  <= {b_v[0], bus.rdb_req};
            b_e  <= {b_e[0], b_err};
            b_b1 <= b_bank;
            b_b2 <= b_b1;
            bus.rda_valid <= a_v[1];
            bus.rda_err   <= a_v[1] & a_e[1];
            bus.rda_data  <= (a_v[1] & ~a_e[1]) ? doa_q[a_b2] : '0;
            bus.rdb_valid <= b_v[1];
            bus.rdb_err   <= b_v[1] & b_e[1];
            bus.rdb_data  <= (b_v[1] & ~b_e[1]) ? dob_q[b_b2] : '0;
        end
    end
endmodule

// File: tb/tb_line_buffer_multi.sv
// Scoreboard bench for line_buffer_multi: a TIMES=1 instance for the main
// flow and a TIMES=3 instance for decimation.
module tb_line_buffer_multi;
    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    line_buffer_multi_if #(.VIDEO_DATA_WIDTH(18), .RAM_DEPTH(100), .NUM_LINES(4)) b1 ();
    line_buffer_multi_if #(.VIDEO_DATA_WIDTH(18), .RAM_DEPTH(100), .NUM_LINES(4)) b2 ();

    line_buffer_multi #(
        .VIDEO_DATA_WIDTH(18), .RAM_DEPTH(100), .NUM_LINES(4), .TIMES(1)
    ) u_dut (.clk(clk), .sclr(sclr), .bus(b1));

    line_buffer_multi #(
        .VIDEO_DATA_WIDTH(18), .RAM_DEPTH(100), .NUM_LINES(4), .TIMES(3)
    ) u_dec (.clk(clk), .sclr(sclr), .bus(b2));

    typedef struct {
        int d;
        int e;
        int c;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int mdat [8][128];
    int mlen [8];
    int nl = 0;
    int mavail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int line, input int addr);
        exp_t e;
        int idx;
        idx = (((nl - 1 - line) % 8) + 8) % 8;
        e.c = cyc;
        if (line >= mavail || addr >= mlen[idx]) begin
            e.d = 0;
            e.e = 1;
        end else begin
            e.d = mdat[idx][addr];
            e.e = 0;
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (b1.rda_valid) begin
            if (qa.size() == 0) chk("a_spurious", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_data", int'(b1.rda_data), e.d);
                chk("a_err", int'(b1.rda_err), e.e);
                chk("a_lat", cyc - e.c, 3);
            end
        end
        if (b1.rdb_valid) begin
            if (qb.size() == 0) chk("b_spurious", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_data", int'(b1.rdb_data), e.d);
                chk("b_err", int'(b1.rdb_err), e.e);
                chk("b_lat", cyc - e.c, 3);
            end
        end
        if (b2.rdb_valid) begin
            if (qc.size() == 0) chk("dec_spurious", 1, 0);
            else begin
                e = qc.pop_front();
                chk("dec_data", int'(b2.rdb_data), e.d);
                chk("dec_err", int'(b2.rdb_err), e.e);
                chk("dec_lat", cyc - e.c, 3);
            end
        end
    end

    task automatic wr_line(input int base, input int n, input bit rd_end);
        int idx;
        for (int i = 0; i < n; i++) begin
            b1.effect_reigon = 1'b1;
            b1.video_data_in = 18'(base + i);
            tick();
        end
        b1.effect_reigon = 1'b0;
        if (rd_end) begin
            b1.rda_req  = 1'b1;
            b1.rda_line = 2'd0;
            b1.rda_addr = 7'd3;
            b1.rdb_req  = 1'b1;
            b1.rdb_line = 2'd0;
            b1.rdb_addr = 7'd3;
            qa.push_back(mk(0, 3));
            qb.push_back(mk(0, 3));
        end
        tick();
        b1.rda_req = 1'b0;
        b1.rdb_req = 1'b0;
        idx = nl % 8;
        for (int j = 0; j < n && j < 100; j++) mdat[idx][j] = base + j;
        mlen[idx] = (n > 100) ? 100 : n;
        nl++;
        if (mavail < 3) mavail++;
        chk("line_done", int'(b1.line_done), 1);
        chk("line_len", int'(b1.line_len), mlen[idx]);
        chk("lines_avail", int'(b1.lines_avail), mavail);
    endtask

    task automatic rd(input bit ea, input int la, input int aa,
                      input bit eb, input int lb, input int ab);
        b1.rda_req  = ea;
        b1.rda_line = 2'(la);
        b1.rda_addr = 7'(aa);
        b1.rdb_req  = eb;
        b1.rdb_line = 2'(lb);
        b1.rdb_addr = 7'(ab);
        if (ea) qa.push_back(mk(la, aa));
        if (eb) qb.push_back(mk(lb, ab));
        tick();
        b1.rda_req = 1'b0;
        b1.rdb_req = 1'b0;
    endtask

    task automatic do_flush();
        b1.flush = 1'b1;
        tick();
        b1.flush = 1'b0;
        mavail = 0;
        chk("flush_avail", int'(b1.lines_avail), 0);
    endtask

    task automatic drain();
        repeat (6) tick();
    endtask

    initial begin
        sclr = 1'b1;
        b1.ce = 1'b1; b1.flush = 1'b0; b1.video_data_in = '0; b1.effect_reigon = 1'b0;
        b1.rda_req = 1'b0; b1.rda_line = '0; b1.rda_addr = '0;
        b1.rdb_req = 1'b0; b1.rdb_line = '0; b1.rdb_addr = '0;
        b2.ce = 1'b1; b2.flush = 1'b0; b2.video_data_in = '0; b2.effect_reigon = 1'b0;
        b2.rda_req = 1'b0; b2.rda_line = '0; b2.rda_addr = '0;
        b2.rdb_req = 1'b0; b2.rdb_line = '0; b2.rdb_addr = '0;
        repeat (2) tick();
        sclr = 1'b0;
        tick();

        chk("rst_avail", int'(b1.lines_avail), 0);
        chk("rst_len", int'(b1.line_len), 0);
        chk("rst_ovf", int'(b1.ovf), 0);
        chk("rst_done", int'(b1.line_done), 0);
        chk("rst_va", int'(b1.rda_valid), 0);
        chk("rst_vb", int'(b1.rdb_valid), 0);
        chk("rst_data", int'(b1.rda_data), 0);

        for (int l = 0; l < 3; l++) wr_line(l * 100, 10, 1'b0);
        rd(1'b1, 2, 5, 1'b1, 1, 0);
        rd(1'b1, 0, 9, 1'b0, 0, 0);
        drain();

        wr_line(300, 10, 1'b0);
        wr_line(400, 10, 1'b0);
        rd(1'b0, 0, 0, 1'b1, 0, 0);
        chk("wr_bank_wrap", int'(u_dut.wr_bank), 1);
        drain();

        rd(1'b1, 3, 0, 1'b1, 0, 10);
        for (int i = 0; i < 6; i++) rd(1'b1, i % 3, i, 1'b1, (i + 1) % 3, 9 - i);
        drain();

        do_flush();
        rd(1'b1, 0, 0, 1'b1, 0, 5);
        drain();

        wr_line(0, 120, 1'b0);
        chk("ovf_set", int'(b1.ovf), 1);
        rd(1'b1, 0, 99, 1'b1, 0, 100);
        drain();

        do_flush();
        wr_line(700, 10, 1'b0);
        wr_line(800, 10, 1'b1);
        rd(1'b1, 0, 3, 1'b1, 1, 3);
        drain();

        b1.rda_req = 1'b1; b1.rdb_req = 1'b1;
        b1.rda_line = 2'd0; b1.rdb_line = 2'd0;
        b1.rda_addr = 7'd1; b1.rdb_addr = 7'd2;
        tick();
        tick();
        sclr = 1'b1;
        b1.rda_req = 1'b0; b1.rdb_req = 1'b0;
        tick();
        sclr = 1'b0;
        mavail = 0;
        chk("sclr_va", int'(b1.rda_valid), 0);
        chk("sclr_vb", int'(b1.rdb_valid), 0);
        chk("sclr_avail", int'(b1.lines_avail), 0);
        chk("sclr_ovf", int'(b1.ovf), 0);
        drain();

        for (int i = 0; i < 9; i++) begin
            b2.effect_reigon = 1'b1;
            b2.video_data_in = 18'(i);
            tick();
        end
        b2.effect_reigon = 1'b0;
        tick();
        chk("dec_done", int'(b2.line_done), 1);
        chk("dec_len", int'(b2.line_len), 3);
        for (int a = 0; a < 4; a++) begin
            exp_t e;
            b2.rdb_req  = 1'b1;
            b2.rdb_line = 2'd0;
            b2.rdb_addr = 7'(a);
            e.d = (a < 3) ? a * 3 : 0;
            e.e = (a < 3) ? 0 : 1;
            e.c = cyc;
            qc.push_back(e);
            tick();
        end
        b2.rdb_req = 1'b0;
        drain();

        chk("a_pending", qa.size(), 0);
        chk("b_pending", qb.size(), 0);
        chk("dec_pending", qc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
